// File: rtl/writeback_commit_arbiter_if.sv
// rtl/writeback_commit_arbiter_if.sv - result-source and commit-side signal bundle for writeback_commit_arbiter
interface writeback_commit_arbiter_if #(
    parameter int NUM_WARP_LOG    = 3,
    parameter int SIZE_CORE       = 8,
    parameter int SIZE_DATA       = 32,
    parameter int SIZE_REGFILE_BR = 6
);
    logic                           intu_valid_i;
    logic [NUM_WARP_LOG-1:0]        intu_warp_i;
    logic [SIZE_REGFILE_BR-1:0]     intu_dest_i;
    logic [SIZE_CORE-1:0]           intu_mask_i;
    logic [SIZE_CORE*SIZE_DATA-1:0] intu_data_i;
    logic                           intu_ready_o;

    logic                           load_valid_i;
    logic [NUM_WARP_LOG-1:0]        load_warp_i;
    logic [SIZE_REGFILE_BR-1:0]     load_dest_i;
    logic [SIZE_CORE-1:0]           load_mask_i;
    logic [SIZE_CORE*SIZE_DATA-1:0] load_data_i;
    logic                           load_ready_o;

    logic                           wb_valid_o;
    logic                           wb_src_o;
    logic                           wb_we_o;
    logic [NUM_WARP_LOG-1:0]        wb_warp_o;
    logic [SIZE_REGFILE_BR-1:0]     wb_dest_o;
    logic [SIZE_CORE-1:0]           wb_mask_o;
    logic [SIZE_CORE*SIZE_DATA-1:0] wb_data_o;
    logic                           sb_intu_commit_o;
    logic                           sb_load_commit_o;

    modport master (
        output intu_valid_i, intu_warp_i, intu_dest_i, intu_mask_i, intu_data_i,
        output load_valid_i, load_warp_i, load_dest_i, load_mask_i, load_data_i,
        input  intu_ready_o, load_ready_o,
        input  wb_valid_o, wb_src_o, wb_we_o, wb_warp_o, wb_dest_o, wb_mask_o, wb_data_o,
        input  sb_intu_commit_o, sb_load_commit_o
    );

    modport slave (
        input  intu_valid_i, intu_warp_i, intu_dest_i, intu_mask_i, intu_data_i,
        input  load_valid_i, load_warp_i, load_dest_i, load_mask_i, load_data_i,
        output intu_ready_o, load_ready_o,
        output wb_valid_o, wb_src_o, wb_we_o, wb_warp_o, wb_dest_o, wb_mask_o, wb_data_o,
        output sb_intu_commit_o, sb_load_commit_o
    );
endinterface

// File: rtl/writeback_commit_arbiter.sv
// rtl/writeback_commit_arbiter.sv - merges INTU/LDST results into one register-file write and scoreboard commit
// Optional WB_BYPASS_EN: an input may skip its empty FIFO into the output register when the block is idle.
module writeback_commit_arbiter #(
    parameter int NUM_WARP_LOG    = 3,
    parameter int SIZE_CORE       = 8,
    parameter int SIZE_DATA       = 32,
    parameter int SIZE_REGFILE_BR = 6,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_i,
    writeback_commit_arbiter_if.slave bus
);
    localparam int ENTRY_W = NUM_WARP_LOG + SIZE_REGFILE_BR + SIZE_CORE + SIZE_CORE * SIZE_DATA;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    typedef logic [ENTRY_W-1:0] entry_t;

    // Index 0 is INTU, index 1 is LDST, matching the wb_src_o encoding.
    entry_t           fifoMem [2][FIFO_DEPTH];
    logic [PTR_W-1:0] rdPtr   [2];
    logic [PTR_W-1:0] wrPtr   [2];
    logic [PTR_W:0]   count   [2];
    entry_t           inEntry [2];
    entry_t           head    [2];

    logic [1:0] inValid;
    logic [1:0] ready;
    logic [1:0] notEmpty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] bypass;
    logic       grant;
    logic       winner;
    logic       takeBypass;
    logic       bypassSrc;
    logic       lastGrant;

    logic       outValid;
    logic       outSrc;
    entry_t     outEntry;

    always_comb begin
        inValid    = {bus.load_valid_i, bus.intu_valid_i};
        inEntry[0] = {bus.intu_warp_i, bus.intu_dest_i, bus.intu_mask_i, bus.intu_data_i};
        inEntry[1] = {bus.load_warp_i, bus.load_dest_i, bus.load_mask_i, bus.load_data_i};
        for (int s = 0; s < 2; s++) begin
            // Depth is a power of two and count never exceeds it, so the MSB alone flags full.
            ready[s]    = ~count[s][PTR_W];
            notEmpty[s] = |count[s];
            head[s]     = fifoMem[s][rdPtr[s]];
        end
    end

    always_comb begin
        grant  = ~stall_i & (|notEmpty);
        winner = (&notEmpty) ? ~lastGrant : notEmpty[1];
        pop    = {grant & winner, grant & ~winner};
`ifdef WB_BYPASS_EN
        // Only when both FIFOs are empty; INTU takes priority if both present together.
        bypassSrc  = ~inValid[0];
        takeBypass = ~stall_i & ~(|notEmpty) & (|inValid);
        bypass     = {takeBypass & bypassSrc, takeBypass & ~bypassSrc};
`else
        bypassSrc  = 1'b0;
        takeBypass = 1'b0;
        bypass     = 2'b00;
`endif
        push = inValid & ready & ~bypass;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                rdPtr[s] <= '0;
                wrPtr[s] <= '0;
                count[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    fifoMem[s][wrPtr[s]] <= inEntry[s];
                    wrPtr[s]             <= wrPtr[s] + PTR_W'(1);
                end
                if (pop[s]) begin
                    rdPtr[s] <= rdPtr[s] + PTR_W'(1);
                end
                if (push[s] && !pop[s]) begin
                    count[s] <= count[s] + (PTR_W+1)'(1);
                end else if (pop[s] && !push[s]) begin
                    count[s] <= count[s] - (PTR_W+1)'(1);
                end
            end
        end
    end

    // Stall freezes the slot entirely; only an unstalled cycle consumes or refills it.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid  <= 1'b0;
            outSrc    <= 1'b0;
            outEntry  <= '0;
            lastGrant <= 1'b1;
        end else if (!stall_i) begin
            if (grant) begin
                outValid  <= 1'b1;
                outSrc    <= winner;
                outEntry  <= head[winner];
                lastGrant <= winner;
            end else if (takeBypass) begin
                outValid  <= 1'b1;
                outSrc    <= bypassSrc;
                outEntry  <= inEntry[bypassSrc];
                lastGrant <= bypassSrc;
            end else begin
                outValid  <= 1'b0;
            end
        end
    end

    assign bus.intu_ready_o = ready[0];
    assign bus.load_ready_o = ready[1];

    assign bus.wb_valid_o = outValid;
    assign bus.wb_src_o   = outSrc;
    assign {bus.wb_warp_o, bus.wb_dest_o, bus.wb_mask_o, bus.wb_data_o} = outEntry;
    assign bus.wb_we_o    = outValid & (|bus.wb_mask_o);

    assign bus.sb_intu_commit_o = outValid & ~outSrc & ~stall_i;
    assign bus.sb_load_commit_o = outValid &  outSrc & ~stall_i;
endmodule

// File: tb/tb_writeback_commit_arbiter.sv
// tb/tb_writeback_commit_arbiter.sv - self-checking bench for writeback_commit_arbiter
module tb_writeback_commit_arbiter;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]   warp;
        logic [5:0]   dest;
        logic [7:0]   mask;
        logic [255:0] data;
    } entry_t;

    typedef struct {
        logic       iv;
        logic       lv;
        logic       st;
        logic [2:0] warp;
        logic [5:0] dest;
        logic [7:0] mask;
        logic       eValid;
        logic       eSrc;
        logic       eWe;
        logic       eSbI;
        logic       eSbL;
        logic [2:0] eWarp;
        logic [5:0] eDest;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    int   errors = 0;
    int   checks = 0;

    entry_t q0[$];
    entry_t q1[$];
    logic   mValid;
    logic   mSrc;
    logic   mLg;
    entry_t mOut;
    bit     commitSrc[$];

    writeback_commit_arbiter_if bus ();

    writeback_commit_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .stall_i (stall),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic entry_t mkEntry(input logic [2:0] w, input logic [5:0] d, input logic [7:0] m);
        entry_t e;
        e.warp = w;
        e.dest = d;
        e.mask = m;
        e.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return e;
    endfunction

    function automatic entry_t rndEntry();
        logic [7:0] m;
        m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        return mkEntry(3'($urandom), 6'($urandom), m);
    endfunction

    task automatic modelReset();
        q0.delete();
        q1.delete();
        mValid = 1'b0;
        mSrc   = 1'b0;
        mOut   = '0;
        mLg    = 1'b1;
    endtask

    task automatic drive(input logic iv, input entry_t ie, input logic lv, input entry_t le, input logic st);
        bus.intu_valid_i = iv;
        bus.intu_warp_i  = ie.warp;
        bus.intu_dest_i  = ie.dest;
        bus.intu_mask_i  = ie.mask;
        bus.intu_data_i  = ie.data;
        bus.load_valid_i = lv;
        bus.load_warp_i  = le.warp;
        bus.load_dest_i  = le.dest;
        bus.load_mask_i  = le.mask;
        bus.load_data_i  = le.data;
        stall            = st;
    endtask

    // One clock: drive at the falling edge, compare against the queue model, then advance the model.
    task automatic cycle(input logic iv, input entry_t ie, input logic lv, input entry_t le,
                         input logic st, output logic iAcc, output logic lAcc);
        logic bypI;
        logic bypL;
        bypI = 1'b0;
        bypL = 1'b0;
        drive(iv, ie, lv, le, st);
        #1;
        chk("intu_ready", bus.intu_ready_o, q0.size() < DEPTH);
        chk("load_ready", bus.load_ready_o, q1.size() < DEPTH);
        chk("wb_valid", bus.wb_valid_o, mValid);
        if (mValid) begin
            chk("wb_src", bus.wb_src_o, mSrc);
            chk("wb_warp", bus.wb_warp_o, mOut.warp);
            chk("wb_dest", bus.wb_dest_o, mOut.dest);
            chk("wb_mask", bus.wb_mask_o, mOut.mask);
            chk("wb_data", bus.wb_data_o, mOut.data);
        end
        chk("wb_we", bus.wb_we_o, mValid && (mOut.mask != 8'h00));
        chk("sb_intu", bus.sb_intu_commit_o, mValid && !mSrc && !st);
        chk("sb_load", bus.sb_load_commit_o, mValid && mSrc && !st);
        if (bus.sb_intu_commit_o || bus.sb_load_commit_o) commitSrc.push_back(bus.wb_src_o);

        iAcc = iv && (q0.size() < DEPTH);
        lAcc = lv && (q1.size() < DEPTH);
        if (!st) begin
            if (q0.size() > 0 && q1.size() > 0) begin
                mSrc = !mLg;
                if (mSrc) mOut = q1.pop_front();
                else      mOut = q0.pop_front();
                mValid = 1'b1;
                mLg    = mSrc;
            end else if (q0.size() > 0) begin
                mOut = q0.pop_front(); mSrc = 1'b0; mValid = 1'b1; mLg = 1'b0;
            end else if (q1.size() > 0) begin
                mOut = q1.pop_front(); mSrc = 1'b1; mValid = 1'b1; mLg = 1'b1;
`ifdef WB_BYPASS_EN
            end else if (iAcc) begin
                mOut = ie; mSrc = 1'b0; mValid = 1'b1; mLg = 1'b0; bypI = 1'b1;
            end else if (lAcc) begin
                mOut = le; mSrc = 1'b1; mValid = 1'b1; mLg = 1'b1; bypL = 1'b1;
`endif
            end else begin
                mValid = 1'b0;
            end
        end
        if (iAcc && !bypI) q0.push_back(ie);
        if (lAcc && !bypL) q1.push_back(le);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        logic b;
        entry_t z;
        z = '0;
        for (int i = 0; i < n; i++) cycle(1'b0, z, 1'b0, z, 1'b0, a, b);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        vec_t   tbl[14];
        entry_t z;
        entry_t ei[8];
        entry_t el[8];
        entry_t pi;
        entry_t pl;
        logic   hasI;
        logic   hasL;
        logic   ia;
        logic   la;
        logic   st;
        int     ni;
        int     nl;
        int     bad;

        z = '0;
        drive(1'b0, z, 1'b0, z, 1'b0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", bus.wb_valid_o, 0);
        chk("rst_src", bus.wb_src_o, 0);
        chk("rst_we", bus.wb_we_o, 0);
        chk("rst_warp", bus.wb_warp_o, 0);
        chk("rst_dest", bus.wb_dest_o, 0);
        chk("rst_mask", bus.wb_mask_o, 0);
        chk("rst_data", bus.wb_data_o, 0);
        chk("rst_sb_intu", bus.sb_intu_commit_o, 0);
        chk("rst_sb_load", bus.sb_load_commit_o, 0);
        chk("rst_intu_ready", bus.intu_ready_o, 1);
        chk("rst_load_ready", bus.load_ready_o, 1);
        @(negedge clk);

`ifndef WB_BYPASS_EN
        //            iv lv st warp dest mask    eV eS eWe eSbI eSbL eWarp eDest
        tbl[0]  = '{0, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 2, 5,  8'hFF, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0,  8'h00, 1, 0, 1, 1, 0, 2, 5};
        tbl[4]  = '{0, 1, 0, 7, 33, 8'h00, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0,  8'h00, 1, 1, 0, 0, 1, 7, 33};
        tbl[7]  = '{1, 0, 0, 1, 9,  8'h0F, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 0,  8'h00, 1, 0, 1, 0, 0, 1, 9};
        tbl[10] = '{0, 0, 1, 0, 0,  8'h00, 1, 0, 1, 0, 0, 1, 9};
        tbl[11] = '{0, 0, 1, 0, 0,  8'h00, 1, 0, 1, 0, 0, 1, 9};
        tbl[12] = '{0, 0, 0, 0, 0,  8'h00, 1, 0, 1, 1, 0, 1, 9};
        tbl[13] = '{0, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 0, 0, 0};
        for (int r = 0; r < 14; r++) begin
            pi = mkEntry(tbl[r].warp, tbl[r].dest, tbl[r].mask);
            drive(tbl[r].iv, pi, tbl[r].lv, pi, tbl[r].st);
            #1;
            chk($sformatf("tbl%0d_valid", r), bus.wb_valid_o, tbl[r].eValid);
            if (tbl[r].eValid) begin
                chk($sformatf("tbl%0d_src", r), bus.wb_src_o, tbl[r].eSrc);
                chk($sformatf("tbl%0d_warp", r), bus.wb_warp_o, tbl[r].eWarp);
                chk($sformatf("tbl%0d_dest", r), bus.wb_dest_o, tbl[r].eDest);
            end
            chk($sformatf("tbl%0d_we", r), bus.wb_we_o, tbl[r].eWe);
            chk($sformatf("tbl%0d_sb_intu", r), bus.sb_intu_commit_o, tbl[r].eSbI);
            chk($sformatf("tbl%0d_sb_load", r), bus.sb_load_commit_o, tbl[r].eSbL);
            chk($sformatf("tbl%0d_ready", r), {bus.intu_ready_o, bus.load_ready_o}, 2'b11);
            @(posedge clk);
            @(negedge clk);
        end
        pulseReset();
`else
        pi = mkEntry(3'd2, 6'd5, 8'hFF);
        cycle(1'b1, pi, 1'b0, z, 1'b0, ia, la);
        #1;
        chk("bypass_valid", bus.wb_valid_o, 1);
        chk("bypass_src", bus.wb_src_o, 0);
        chk("bypass_sb_intu", bus.sb_intu_commit_o, 1);
        @(negedge clk);
        cycle(1'b0, z, 1'b0, z, 1'b0, ia, la);
        idle(2);
`endif

        // Both sources pushing back-to-back.
        for (int k = 0; k < 8; k++) begin
            ei[k] = rndEntry();
            el[k] = rndEntry();
        end
        commitSrc.delete();
        ni = 0;
        nl = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(ni < 8, ei[ni % 8], nl < 8, el[nl % 8], 1'b0, ia, la);
            if (ia) ni++;
            if (la) nl++;
        end
        chk("both_commits", commitSrc.size(), 16);
`ifndef WB_BYPASS_EN
        if (commitSrc.size() == 16) begin
            bad = 0;
            for (int k = 1; k < 16; k++) if (commitSrc[k] == commitSrc[k-1]) bad++;
            chk("both_alternate", bad, 0);
            chk("both_first_intu", commitSrc[0], 0);
        end
`endif

        // Fill LDST under stall: fifth entry is held by the source.
        for (int k = 0; k < 5; k++) el[k] = rndEntry();
        nl = 0;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, z, nl < 5, el[nl % 8], 1'b1, ia, la);
            if (la) nl++;
        end
        #1;
        chk("fill_accepted", nl, 4);
        chk("fill_load_ready", bus.load_ready_o, 0);
        @(negedge clk);
        commitSrc.delete();
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, z, nl < 5, el[nl % 8], 1'b0, ia, la);
            if (la) nl++;
        end
        chk("fill_commits", commitSrc.size(), 5);

        // Reset with three INTU entries queued.
        for (int c = 0; c < 3; c++) cycle(1'b1, rndEntry(), 1'b0, z, 1'b1, ia, la);
        drive(1'b0, z, 1'b0, z, 1'b0);
        pulseReset();
        commitSrc.delete();
        idle(5);
        chk("rst_mid_commits", commitSrc.size(), 0);
        chk("rst_mid_ready", {bus.intu_ready_o, bus.load_ready_o}, 2'b11);

        // Random traffic with held-until-accepted sources.
        hasI = 1'b0;
        hasL = 1'b0;
        pi = '0;
        pl = '0;
        for (int c = 0; c < 400; c++) begin
            if (!hasI && $urandom_range(0, 1) == 1) begin pi = rndEntry(); hasI = 1'b1; end
            if (!hasL && $urandom_range(0, 1) == 1) begin pl = rndEntry(); hasL = 1'b1; end
            st = ($urandom_range(0, 3) == 0);
            cycle(hasI, pi, hasL, pl, st, ia, la);
            if (ia) hasI = 1'b0;
            if (la) hasL = 1'b0;
        end
        idle(12);
        chk("drain_intu_empty", q0.size(), 0);
        chk("drain_load_empty", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
